serial_add_ctrl: RTL



---
 rtl/serial_add_ctrl_pkg.sv | 13 +
 rtl/serial_add_ctrl_add1b.sv | 13 +
 rtl/serial_add_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encodings
// and the default operand width.
package serial_add_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_add1b.sv
// Single-bit full-adder cell; the controller reuses it once per operand bit.
module add1b (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic r,
   output logic co
);

   assign r  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one add1b cell LSB-first for WIDTH cycles,
// linking the cycles through a registered carry, with a start/done handshake.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t             state_r;
   state_t             state_s;
   logic               load_s;
   logic               run_s;
   logic               last_s;
   logic [WIDTH-1:0]   sa_r;
   logic [WIDTH-1:0]   sb_r;
   logic               carry_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               cell_r_s;
   logic               cell_co_s;

   add1b u_add1b (
      .a  (sa_r[0]),
      .b  (sb_r[0]),
      .ci (carry_r),
      .r  (cell_r_s),
      .co (cell_co_s)
   );

   // Next-state decode plus load/shift/last-bit strobes for the datapath.
   always_comb begin
      state_s = state_r;
      load_s  = 1'b0;
      run_s   = 1'b0;
      last_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = RUN;
               load_s  = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            run_s = 1'b1;
            if (cnt_r == LAST_CNT) begin
               last_s  = 1'b1;
               state_s = DONE;
            end else begin
               state_s = RUN;
            end
         end
         DONE: begin
            if (start) begin
               state_s = RUN;
               load_s  = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register; busy/done are registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_r <= state_s;
         busy    <= (state_s == RUN);
         done    <= (state_s == DONE);
      end
   end

   // Operand shifters, carry chain, bit counter and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sa_r    <= '0;
         sb_r    <= '0;
         carry_r <= 1'b0;
         cnt_r   <= '0;
         sum     <= '0;
         co      <= 1'b0;
         ovf     <= 1'b0;
      end else if (load_s) begin
         sa_r    <= a;
         sb_r    <= b;
         carry_r <= ci;
         cnt_r   <= '0;
         sum     <= '0;
      end else if (run_s) begin
         sa_r    <= {1'b0, sa_r[WIDTH-1:1]};
         sb_r    <= {1'b0, sb_r[WIDTH-1:1]};
         sum     <= {cell_r_s, sum[WIDTH-1:1]};
         carry_r <= cell_co_s;
         cnt_r   <= cnt_r + CNT_ONE;
         // On the MSB step carry_r still holds the carry into the MSB.
         if (last_s) begin
            co  <= cell_co_s;
            ovf <= carry_r ^ cell_co_s;
         end
      end
   end

endmodule
